// File: rtl/datamemory_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, FSM states,
// the response pipeline payload and the alignment rule used by both lane paths.
package datamemory_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Everything the output formatter needs about one accepted request.
    typedef struct packed {
        logic              load;
        size_e             size;
        logic [1:0]        lane;
        logic              uns;
        logic [DATA_W-1:0] word;
    } resp_meta_t;

    // Half needs an even byte address, word needs a word-aligned one,
    // the reserved size is never legal.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/datamemory_bytelane_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface datamemory_bytelane_if
    import datamemory_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] addr;
    logic [DATA_W-1:0] din;
    logic              resp_valid;
    logic [DATA_W-1:0] S_datamemory;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, addr, din,
        input  req_ready, resp_valid, S_datamemory, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, addr, din,
        output req_ready, resp_valid, S_datamemory, resp_err
    );
endinterface

// File: rtl/datamemory_lane_fmt.sv
// Combinational lane formatter. Store path: byte enables plus store data
// replicated onto every lane. Load path: lane select plus sign/zero extension.
// Both views are computed; STORE_PATH picks which one drives o_data.
module datamemory_lane_fmt
    import datamemory_pkg::*;
#(
    parameter bit STORE_PATH = 1'b1
) (
    input  size_e             i_size,
    input  logic [1:0]        i_lane,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [3:0]        o_be,
    output logic              o_err
);

    logic [DATA_W-1:0] w_st_word;
    logic [DATA_W-1:0] w_ld_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Lane mask, replicated store word and extended load word for one access.
    always_comb begin
        o_err     = misaligned(i_size, i_lane);
        o_be      = 4'b0000;
        w_st_word = '0;
        w_ld_word = '0;
        w_byte    = i_data[{i_lane, 3'b000} +: 8];
        w_half    = i_lane[1] ? i_data[31:16] : i_data[15:0];
        if (!o_err) begin
            case (i_size)
                SZ_BYTE: begin
                    o_be      = 4'b0001 << i_lane;
                    w_st_word = {4{i_data[7:0]}};
                    w_ld_word = i_unsigned ? {24'b0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
                end
                SZ_HALF: begin
                    o_be      = i_lane[1] ? 4'b1100 : 4'b0011;
                    w_st_word = {2{i_data[15:0]}};
                    w_ld_word = i_unsigned ? {16'b0, w_half}
                                           : {{16{w_half[15]}}, w_half};
                end
                SZ_WORD: begin
                    o_be      = 4'b1111;
                    w_st_word = i_data;
                    w_ld_word = i_data;
                end
                default: ;
            endcase
        end
        o_data = STORE_PATH ? w_st_word : w_ld_word;
    end

endmodule

// File: rtl/datamemory_bytelane.sv
// MIPS data memory with byte/half/word lanes, valid/ready requests, an
// optional post-reset clear sweep and a 1- or 2-stage registered read.
module datamemory_bytelane
    import datamemory_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    datamemory_bytelane_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;

    logic              w_ready;
    logic              w_accept;
    logic [ADDR_W-1:0] w_idx;

    logic [DATA_W-1:0] w_st_data;
    logic [3:0]        w_st_be;
    logic              w_st_err;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;
    logic [3:0]        w_wr_be;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_vld_p1;
    resp_meta_t        r_meta_p1;
    resp_meta_t        w_meta_in;

    logic              w_out_vld;
    resp_meta_t        w_out_meta;

    logic [DATA_W-1:0] w_ld_data;
    logic [3:0]        w_ld_be;
    logic              w_ld_err;

    assign w_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept = bus.req_valid && w_ready;
    assign w_idx    = bus.addr[ADDR_W+1:2];

    // State register and clear pointer; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR)
                r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
        end
    end

    // Leave CLEAR once the last word has been zeroed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_ptr == {ADDR_W{1'b1}}) w_state_nxt = ST_IDLE;
            ST_IDLE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    datamemory_lane_fmt #(
        .STORE_PATH (1'b1)
    ) u_st_fmt (
        .i_size     (size_e'(bus.req_size)),
        .i_lane     (bus.addr[1:0]),
        .i_unsigned (bus.req_unsigned),
        .i_data     (bus.din),
        .o_data     (w_st_data),
        .o_be       (w_st_be),
        .o_err      (w_st_err)
    );

    // Single write port shared by the clear sweep and accepted stores.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_idx;
        w_wr_data = w_st_data;
        w_wr_be   = w_st_be;
        if (!rst && r_state == ST_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_clr_ptr;
            w_wr_data = '0;
            w_wr_be   = 4'b1111;
        end else if (w_accept && bus.req_we && !w_st_err) begin
            w_wr_en = 1'b1;
        end
    end

    // Byte-enabled array write; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_be[i])
                    r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_meta_in.load = !bus.req_we;
        w_meta_in.size = size_e'(bus.req_size);
        w_meta_in.lane = bus.addr[1:0];
        w_meta_in.uns  = bus.req_unsigned;
        w_meta_in.word = r_mem[w_idx];
    end

    // Stage p1: capture the addressed word and request attributes at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_meta_p1 <= '0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept)
                r_meta_p1 <= w_meta_in;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic       r_vld_p2;
            resp_meta_t r_meta_p2;

            // Stage p2: one extra register stage; payload held between responses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p2  <= 1'b0;
                    r_meta_p2 <= '0;
                end else begin
                    r_vld_p2 <= r_vld_p1;
                    if (r_vld_p1)
                        r_meta_p2 <= r_meta_p1;
                end
            end

            assign w_out_vld  = r_vld_p2;
            assign w_out_meta = r_meta_p2;
        end else begin : g_lat1
            assign w_out_vld  = r_vld_p1;
            assign w_out_meta = r_meta_p1;
        end
    endgenerate

    datamemory_lane_fmt #(
        .STORE_PATH (1'b0)
    ) u_ld_fmt (
        .i_size     (w_out_meta.size),
        .i_lane     (w_out_meta.lane),
        .i_unsigned (w_out_meta.uns),
        .i_data     (w_out_meta.word),
        .o_data     (w_ld_data),
        .o_be       (w_ld_be),
        .o_err      (w_ld_err)
    );

    // Output formatting: stores and errors return zero; a response visible
    // while rst is high belongs to discarded traffic and is suppressed.
    assign bus.req_ready    = w_ready;
    assign bus.resp_valid   = w_out_vld && !rst;
    assign bus.resp_err     = w_ld_err;
    assign bus.S_datamemory = (w_out_meta.load && !w_ld_err && (|w_ld_be)) ? w_ld_data : '0;

endmodule

// File: tb/tb_datamemory_bytelane.sv
// Directed bench for datamemory_bytelane (ADDR_W=10, READ_LATENCY=1, clear on reset).
module tb_datamemory_bytelane;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    datamemory_bytelane_if #(.ADDR_W(10)) bus ();

    datamemory_bytelane #(
        .ADDR_W         (10),
        .READ_LATENCY   (1),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [11:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.addr         = a;
        bus.din          = d;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [11:0] a, input logic [31:0] d,
                          output logic v, output logic [31:0] q, output logic e);
        int w;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout: got %b want 1", bus.req_ready);
        end
        drive(we, sz, uns, a, d);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        v = bus.resp_valid;
        q = bus.S_datamemory;
        e = bus.resp_err;
    endtask

    task automatic test_reset;
        int cnt;
        logic v; logic [31:0] q; logic e;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.S_datamemory !== 32'h0 ||
            bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b q=%h e=%b rdy=%b want v=0 q=00000000 e=0 rdy=0",
                     bus.resp_valid, bus.S_datamemory, bus.resp_err, bus.req_ready);
        end
        rst = 1'b0;
        cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (cnt !== 1024) begin
            n_fail++;
            $display("FAIL clear_cycles: got %0d want 1024", cnt);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h3FC, 32'h0, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h0000_0000 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_3fc_after_clear: got v=%b q=%h e=%b want v=1 q=00000000 e=0", v, q, e);
        end
    endtask

    task automatic test_word;
        logic v; logic [31:0] q; logic e;
        do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'h1234_5678, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_010_resp: got v=%b q=%h e=%b want v=1 q=00000000 e=0", v, q, e);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h1234_5678 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_010: got v=%b q=%h e=%b want v=1 q=12345678 e=0", v, q, e);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.S_datamemory !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%b q=%h want v=0 q=12345678", bus.resp_valid, bus.S_datamemory);
        end
    endtask

    task automatic test_byte;
        logic v; logic [31:0] q; logic e;
        do_req(1'b1, 2'b00, 1'b0, 12'h011, 32'h0000_00AB, v, q, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h1234_AB78 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_lane1_word: got v=%b q=%h e=%b want v=1 q=1234ab78 e=0", v, q, e);
        end
        do_req(1'b0, 2'b00, 1'b0, 12'h011, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'hFFFF_FFAB || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_011: got q=%h e=%b want q=ffffffab e=0", q, e);
        end
        do_req(1'b0, 2'b00, 1'b1, 12'h011, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0000_00AB || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lbu_011: got q=%h e=%b want q=000000ab e=0", q, e);
        end
    endtask

    task automatic test_half;
        logic v; logic [31:0] q; logic e;
        do_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0000_1234 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_012_pos: got q=%h e=%b want q=00001234 e=0", q, e);
        end
        do_req(1'b1, 2'b01, 1'b0, 12'h012, 32'h0000_8001, v, q, e);
        do_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'hFFFF_8001 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_012_neg: got q=%h e=%b want q=ffff8001 e=0", q, e);
        end
        do_req(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0000_8001 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lhu_012: got q=%h e=%b want q=00008001 e=0", q, e);
        end
        do_req(1'b1, 2'b00, 1'b0, 12'h013, 32'hFFFF_FF7F, v, q, e);
        do_req(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0000_007F) begin
            n_fail++;
            $display("FAIL lb_013_pos: got q=%h want q=0000007f", q);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h7F01_AB78) begin
            n_fail++;
            $display("FAIL lw_010_merged: got q=%h want q=7f01ab78", q);
        end
    endtask

    task automatic test_errors;
        logic v; logic [31:0] q; logic e;
        do_req(1'b0, 2'b10, 1'b0, 12'h011, 32'h0, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_misaligned: got v=%b q=%h e=%b want v=1 q=00000000 e=1", v, q, e);
        end
        do_req(1'b1, 2'b10, 1'b0, 12'h002, 32'hFFFF_FFFF, v, q, e);
        n_checks++;
        if (v !== 1'b1 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_misaligned: got v=%b e=%b want v=1 e=1", v, e);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_000_unchanged: got q=%h e=%b want q=00000000 e=0", q, e);
        end
        do_req(1'b1, 2'b01, 1'b0, 12'h001, 32'h0000_BEEF, v, q, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL sh_misaligned_nowrite: got q=%h want q=00000000", q);
        end
        do_req(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL size_rsvd: got v=%b q=%h e=%b want v=1 q=00000000 e=1", v, q, e);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFE_F00D);
        @(posedge clk); #1;
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.S_datamemory !== 32'h0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_store: got v=%b q=%h e=%b want v=1 q=00000000 e=0",
                     bus.resp_valid, bus.S_datamemory, bus.resp_err);
        end
        drive(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
        @(posedge clk); #1;
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.S_datamemory !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL b2b_load_after_store: got v=%b q=%h want v=1 q=cafef00d",
                     bus.resp_valid, bus.S_datamemory);
        end
        drive(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.S_datamemory !== 32'h7F01_AB78) begin
            n_fail++;
            $display("FAIL b2b_third: got v=%b q=%h want v=1 q=7f01ab78",
                     bus.resp_valid, bus.S_datamemory);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.S_datamemory !== 32'h7F01_AB78) begin
            n_fail++;
            $display("FAIL b2b_gap_hold: got v=%b q=%h want v=0 q=7f01ab78",
                     bus.resp_valid, bus.S_datamemory);
        end
    endtask

    task automatic test_reset_midflight;
        int cnt;
        logic v; logic [31:0] q; logic e;
        drive(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_discard: got v=%b rdy=%b want v=0 rdy=0",
                     bus.resp_valid, bus.req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.S_datamemory !== 32'h0) begin
            n_fail++;
            $display("FAIL midflight_after_edge: got v=%b q=%h want v=0 q=00000000",
                     bus.resp_valid, bus.S_datamemory);
        end
        rst = 1'b0;
        cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (cnt !== 1024) begin
            n_fail++;
            $display("FAIL reclear_cycles: got %0d want 1024", cnt);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, v, q, e);
        n_checks++;
        if (v !== 1'b1 || q !== 32'h0) begin
            n_fail++;
            $display("FAIL lw_010_recleared: got v=%b q=%h want v=1 q=00000000", v, q);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, v, q, e);
        n_checks++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL lw_020_recleared: got q=%h want q=00000000", q);
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.addr         = '0;
        bus.din          = '0;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_back_to_back;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
